envelope_follower: RTL
======================

// Module: envelope_follower
// PURPOSE
//  Amplitude demodulator: recovers the slow envelope from a signed audio stream, e.g. the output of amp_modulator.
//  Two-stage pipeline: saturating full-wave rectifier, then attack/release one-pole smoother with a small state machine.
//  Feeds gain metering and downstream dynamics; sits after amp_modulator in the signal chain.
// PARAMETERS
//  DATA_WIDTH     16  width of signal_i / env_o (signed two's complement)
//  FRAC_BITS       8  fractional bits kept in the internal accumulator
//  ATTACK_SHIFT    2  attack coefficient = 2^-ATTACK_SHIFT per sample
//  RELEASE_SHIFT   6  release coefficient = 2^-RELEASE_SHIFT per sample
//  HOLD_SAMPLES   64  peak-hold length in valid samples (PEAK_HOLD_EN only, >=1)
// PORTS
//  clk_i      in   1           clock
//  rst_i      in   1           synchronous reset, active-high
//  valid_i    in   1           signal_i carries a sample this cycle; no backpressure
//  signal_i   in   DATA_WIDTH  signed input sample
//  valid_o    out  1           one-cycle pulse: env_o updated
//  env_o      out  DATA_WIDTH  signed envelope, always >= 0
//  attack_o   out  1           1 while FSM is in ATTACK
// BEHAVIOUR
//  - Reset: acc=0, env_o=0, valid_o=0, attack_o=0, state=IDLE, hold_cnt=0, stage-1 valid cleared; in-flight samples discarded.
//  - Stage 1 (on valid_i): rect_q <= |signal_i|; -2^(DW-1) saturates to 2^(DW-1)-1; v1 <= valid_i.
//  - Stage 2 (on v1): acc is DW+FRAC_BITS bits; target = rect_q << FRAC_BITS; diff = target - acc, computed 1 bit wider.
//    ATTACK:  acc += diff >>> ATTACK_SHIFT.
//    RELEASE: acc += diff >>> RELEASE_SHIFT.
//    If diff != 0 and the shifted step is 0, step = sign(diff)*1 (guaranteed convergence).
//    HOLD: acc unchanged.
//  - env_o = acc >> FRAC_BITS, registered with valid_o. Latency valid_i -> valid_o = 2 cycles.
//  - Gaps in valid_i freeze all state. Back-to-back valid_i yields back-to-back valid_o.
//  - FSM (evaluated per stage-2 sample, diff as above):
//    IDLE:    diff>0 -> ATTACK; else stay.
//    ATTACK:  diff>0 -> stay; else -> HOLD (load hold_cnt=HOLD_SAMPLES-1) if PEAK_HOLD_EN, otherwise -> RELEASE.
//    HOLD:    diff>0 -> ATTACK; hold_cnt==0 -> RELEASE; else hold_cnt--.
//    RELEASE: diff>0 -> ATTACK; acc becomes 0 -> IDLE.
//    On the transitioning sample, the new state's rule applies (e.g. ATTACK->RELEASE decays that same sample).
//  - attack_o is registered and reflects the state after the update; it changes with valid_o.
// CONFIGURATION
//  - PEAK_HOLD_EN defined: HOLD state and hold_cnt ($clog2(HOLD_SAMPLES) bits) are present.
//    The envelope is frozen for HOLD_SAMPLES samples after each peak.
//  - PEAK_HOLD_EN undefined: no HOLD state or counter; ATTACK goes directly to RELEASE; HOLD_SAMPLES is ignored.
// STRUCTURE
//  - envelope_pkg: typedef enum logic [1:0] env_state_e {IDLE, ATTACK, HOLD, RELEASE};
//    function sat_abs(); localparam ACC_W = DATA_WIDTH+FRAC_BITS.
//  - Sub-module env_rectifier (stage 1: saturating abs + valid register).
//  - FSM and smoother live in envelope_follower.
// TESTING (defaults unless noted)
//  1. Step 0 -> DC 16384 every cycle:
//     first valid_o env_o=4096, second 7168; reaches 16384 exactly; attack_o=1 until then.
//  2. After settling at 16384, DC 0, no PEAK_HOLD_EN:
//     first env_o=16128, second 15876; monotonic decay to 0; FSM ends IDLE.
//  3. Same as 2 with PEAK_HOLD_EN: env_o stays 16384 for 64 outputs, then 16128, 15876, ...
//     Re-raising input during HOLD -> ATTACK immediately.
//  4. signal_i = -32768 held -> envelope converges to 32767, never wraps negative.
//     valid_i toggled 1/0 -> valid_o mirrors valid_i delayed 2 cycles.
//  5. Assert rst_i for 1 cycle mid-attack -> next cycle env_o=0, valid_o=0, attack_o=0.
//     A sample accepted one cycle before reset produces no valid_o.
//  6. 256-sample sine (amp 16384) times a slow sine modulator, as driven into amp_modulator:
//     env_o peaks track the modulator magnitude within 10%; no X on outputs.

Source files
------------

// File: rtl/envelope_pkg.sv
// Shared types and helpers for the envelope follower: FSM state encoding,
// default widths and the saturating absolute value used by the rectifier.
package envelope_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } env_state_e;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_FRAC_BITS  = 8;
  localparam int unsigned ACC_W          = DEF_DATA_WIDTH + DEF_FRAC_BITS;

  // Widest sample the helper handles; callers sign-extend into this width.
  localparam int unsigned SAT_W = 32;

  // |x| for a w-bit signed value held sign-extended in SAT_W bits; the most
  // negative w-bit value maps to the most positive one instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_abs(input logic signed [SAT_W-1:0] x,
                                               input int unsigned w);
    logic signed [SAT_W-1:0] most_neg;
    logic [SAT_W-1:0]        max_pos;
    most_neg = '1 << (w - 1);
    max_pos  = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    if (x == most_neg) begin
      return max_pos;
    end else if (x < 0) begin
      return SAT_W'(-x);
    end else begin
      return SAT_W'(x);
    end
  endfunction

endpackage

// File: rtl/env_rectifier.sv
// Stage 1 of the envelope follower: registers the saturating full-wave
// rectified sample together with its valid flag.
module env_rectifier
  import envelope_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] signal_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] rect_o
);

  logic signed [SAT_W-1:0] sig_ext;

  assign sig_ext = SAT_W'($signed(signal_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      rect_o  <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        rect_o <= DATA_WIDTH'(sat_abs(sig_ext, DATA_WIDTH));
      end
    end
  end

endmodule

// File: rtl/envelope_follower.sv
// Amplitude demodulator: rectifier stage followed by an attack/release one-pole
// smoother. Define PEAK_HOLD_EN to add the HOLD state that freezes each peak.
module envelope_follower
  import envelope_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned FRAC_BITS     = DEF_FRAC_BITS,
  parameter int unsigned ATTACK_SHIFT  = 2,
  parameter int unsigned RELEASE_SHIFT = 6,
  parameter int unsigned HOLD_SAMPLES  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] signal_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] env_o,
  output logic                  attack_o
);

  localparam int unsigned AccW  = DATA_WIDTH + FRAC_BITS;
  localparam int unsigned DiffW = AccW + 1;

  logic                  v1;
  logic [DATA_WIDTH-1:0] rect;

  env_state_e              state_q;
  logic signed [AccW-1:0]  acc_q;
  logic signed [DiffW-1:0] target, diff, att_step, rel_step;
  logic signed [AccW-1:0]  acc_att, acc_rel;
  logic                    diff_pos;

`ifdef PEAK_HOLD_EN
  localparam int unsigned HoldW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  logic [HoldW-1:0] hold_cnt_q;
`else
  logic unused_hold_cfg;
  assign unused_hold_cfg = ^HOLD_SAMPLES;
`endif

  env_rectifier #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rectifier (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .signal_i(signal_i),
    .valid_o (v1),
    .rect_o  (rect)
  );

  // Candidate accumulator values for both coefficients; the FSM picks one.
  // A step that shifts to zero is forced to +/-1 so the output always settles.
  always_comb begin
    target   = $signed({1'b0, rect, {FRAC_BITS{1'b0}}});
    diff     = target - $signed({acc_q[AccW-1], acc_q});
    diff_pos = !diff[DiffW-1] && (diff != '0);
    att_step = diff >>> ATTACK_SHIFT;
    if ((diff != '0) && (att_step == '0)) begin
      att_step = diff[DiffW-1] ? '1 : DiffW'(1);
    end
    rel_step = diff >>> RELEASE_SHIFT;
    if ((diff != '0) && (rel_step == '0)) begin
      rel_step = diff[DiffW-1] ? '1 : DiffW'(1);
    end
    acc_att = AccW'($signed({acc_q[AccW-1], acc_q}) + att_step);
    acc_rel = AccW'($signed({acc_q[AccW-1], acc_q}) + rel_step);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      env_o      <= '0;
      valid_o    <= 1'b0;
      attack_o   <= 1'b0;
`ifdef PEAK_HOLD_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      valid_o <= v1;
      if (v1) begin
        case (state_q)
          IDLE: begin
            if (diff_pos) begin
              state_q  <= ATTACK;
              acc_q    <= acc_att;
              env_o    <= acc_att[AccW-1:FRAC_BITS];
              attack_o <= 1'b1;
            end
          end
          ATTACK: begin
            if (diff_pos) begin
              acc_q    <= acc_att;
              env_o    <= acc_att[AccW-1:FRAC_BITS];
              attack_o <= 1'b1;
            end else begin
              attack_o <= 1'b0;
`ifdef PEAK_HOLD_EN
              state_q    <= HOLD;
              hold_cnt_q <= HoldW'(HOLD_SAMPLES - 1);
`else
              state_q <= (acc_rel == '0) ? IDLE : RELEASE;
              acc_q   <= acc_rel;
              env_o   <= acc_rel[AccW-1:FRAC_BITS];
`endif
            end
          end
`ifdef PEAK_HOLD_EN
          HOLD: begin
            if (diff_pos) begin
              state_q  <= ATTACK;
              acc_q    <= acc_att;
              env_o    <= acc_att[AccW-1:FRAC_BITS];
              attack_o <= 1'b1;
            end else if (hold_cnt_q == '0) begin
              state_q <= (acc_rel == '0) ? IDLE : RELEASE;
              acc_q   <= acc_rel;
              env_o   <= acc_rel[AccW-1:FRAC_BITS];
            end else begin
              hold_cnt_q <= hold_cnt_q - HoldW'(1);
            end
          end
`endif
          RELEASE: begin
            if (diff_pos) begin
              state_q  <= ATTACK;
              acc_q    <= acc_att;
              env_o    <= acc_att[AccW-1:FRAC_BITS];
              attack_o <= 1'b1;
            end else begin
              state_q <= (acc_rel == '0) ? IDLE : RELEASE;
              acc_q   <= acc_rel;
              env_o   <= acc_rel[AccW-1:FRAC_BITS];
            end
          end
          default: begin
            state_q  <= IDLE;
            attack_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
